// File: rtl/serial_pattern_pkg.sv
// Shared types and defaults for the serial pattern transmitter and its users.
package serial_pattern_pkg;

    localparam int unsigned DEF_PAT_WIDTH = 9;
    localparam int unsigned DEF_LEN_WIDTH = 4;
    localparam int unsigned DEF_CNT_WIDTH = 4;

    // Stimulus that exercises the sequence-detecting Moore machines.
    localparam logic [DEF_PAT_WIDTH-1:0] DETECT_TEST_PATTERN = 9'b001011110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/pattern_shift_reg.sv
// Parallel-load, shift-left register presenting its MSB; load beats shift.
module pattern_shift_reg #(
    parameter int unsigned PAT_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 state_reset,
    input  logic                 load,
    input  logic                 shift,
    input  logic [PAT_WIDTH-1:0] din,
    output logic                 msb
);

    logic [PAT_WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge state_reset) begin
        if (!state_reset) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= din;
        end else if (shift) begin
            r_data <= {r_data[PAT_WIDTH-2:0], 1'b0};
        end
    end

    assign msb = r_data[PAT_WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Shifts a captured pattern out MSB-first, one bit per clock, for N passes or until abort.
module serial_pattern_tx
    import serial_pattern_pkg::*;
#(
    parameter int unsigned PAT_WIDTH = DEF_PAT_WIDTH,
    parameter int unsigned LEN_WIDTH = DEF_LEN_WIDTH,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 state_reset,
    input  logic                 start,
    input  logic [PAT_WIDTH-1:0] pattern,
    input  logic [LEN_WIDTH-1:0] pat_len,
    input  logic [CNT_WIDTH-1:0] reps,
    input  logic                 abort,
    output logic                 r,
    output logic                 r_valid,
    output logic                 busy,
    output logic                 done
);

    localparam logic [LEN_WIDTH-1:0] FULL_LEN = LEN_WIDTH'(PAT_WIDTH);

    tx_state_t              r_state;
    tx_state_t              w_state_nxt;
    logic [PAT_WIDTH-1:0]   r_pattern;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_bit_cnt;
    logic [CNT_WIDTH-1:0]   r_pass_cnt;
    logic [LEN_WIDTH-1:0]   w_len_clamp;
    logic [PAT_WIDTH-1:0]   w_load_din;
    logic                   w_pass_end;
    logic                   w_more;
    logic                   w_capture;
    logic                   w_advance;
    logic                   w_load;
    logic                   w_shift;
    logic                   w_msb;

    assign w_len_clamp = ((pat_len == '0) || (pat_len > FULL_LEN)) ? FULL_LEN : pat_len;
    assign w_pass_end  = (r_bit_cnt == (r_len - LEN_WIDTH'(1)));
    // A captured pass count of zero never decrements, so it keeps meaning "continuous".
    assign w_more      = (r_pass_cnt == '0) || (r_pass_cnt > CNT_WIDTH'(1));
    assign w_load_din  = (r_state == ST_IDLE) ? pattern : r_pattern;

    always_ff @(posedge clk or negedge state_reset) begin
        if (!state_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                    w_load      = 1'b1;
                    w_capture   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_advance = 1'b1;
                    if (!w_pass_end) begin
                        w_shift = 1'b1;
                    end else if (w_more) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Captured configuration plus bit and pass counters.
    always_ff @(posedge clk or negedge state_reset) begin
        if (!state_reset) begin
            r_pattern  <= '0;
            r_len      <= '0;
            r_bit_cnt  <= '0;
            r_pass_cnt <= '0;
        end else if (w_capture) begin
            r_pattern  <= pattern;
            r_len      <= w_len_clamp;
            r_bit_cnt  <= '0;
            r_pass_cnt <= reps;
        end else if (w_advance) begin
            if (w_pass_end) begin
                r_bit_cnt <= '0;
                if (r_pass_cnt > CNT_WIDTH'(1)) begin
                    r_pass_cnt <= r_pass_cnt - CNT_WIDTH'(1);
                end
            end else begin
                r_bit_cnt <= r_bit_cnt + LEN_WIDTH'(1);
            end
        end
    end

    pattern_shift_reg #(
        .PAT_WIDTH(PAT_WIDTH)
    ) u_shift_reg (
        .clk        (clk),
        .state_reset(state_reset),
        .load       (w_load),
        .shift      (w_shift),
        .din        (w_load_din),
        .msb        (w_msb)
    );

    assign r_valid = (r_state == ST_SHIFT);
    assign r       = r_valid & w_msb;
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx; outputs compared as {r, r_valid, busy, done}.
module tb_serial_pattern_tx;

    logic       clk;
    logic       state_reset;
    logic       start;
    logic [8:0] pattern;
    logic [3:0] pat_len;
    logic [3:0] reps;
    logic       abort;
    logic       r;
    logic       r_valid;
    logic       busy;
    logic       done;

    int checks;
    int failures;

    serial_pattern_tx dut (
        .clk        (clk),
        .state_reset(state_reset),
        .start      (start),
        .pattern    (pattern),
        .pat_len    (pat_len),
        .reps       (reps),
        .abort      (abort),
        .r          (r),
        .r_valid    (r_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {r, r_valid, busy, done};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expect L valid bits taken from exp_bits (first bit in exp_bits[L-1]), one per cycle.
    task automatic expect_bits(input string tag, input logic [31:0] exp_bits, input int len);
        logic [31:0] v;
        v = exp_bits;
        for (int k = 0; k < len; k++) begin
            chk($sformatf("%s_bit%0d", tag, k), {v[len-1-k], 3'b110});
            tick();
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        state_reset = 1'b0;
        start       = 1'b0;
        pattern     = '0;
        pat_len     = '0;
        reps        = '0;
        abort       = 1'b0;

        #2;
        chk("reset", 4'b0000);
        @(negedge clk);
        state_reset = 1'b1;
        tick();
        chk("idle_after_reset", 4'b0000);

        // Single pass, full width
        pattern = 9'b001011110; pat_len = 4'd0; reps = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        expect_bits("single", 32'b001011110, 9);
        chk("single_done", 4'b0011);
        tick();
        chk("single_idle", 4'b0000);

        // Short length, two passes, inputs disturbed mid-pass
        pattern = 9'b101000000; pat_len = 4'd3; reps = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("short_bit0", 4'b1110);
        tick();
        pattern = 9'h1FF; pat_len = 4'd1; reps = 4'd5; start = 1'b1;
        chk("short_bit1", 4'b0110);
        tick();
        start = 1'b0;
        expect_bits("short_rest", 32'b1101, 4);
        chk("short_done", 4'b0011);
        tick();
        chk("short_idle", 4'b0000);

        // Abort while idle has no effect
        abort = 1'b1;
        tick();
        chk("abort_idle", 4'b0000);

        // Start and abort together in IDLE: start wins; continuous mode
        pattern = 9'b110000000; pat_len = 4'd4; reps = 4'd0; start = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        expect_bits("cont_p0", 32'b1100, 4);
        expect_bits("cont_p1", 32'b1100, 4);
        expect_bits("cont_p2", 32'b1100, 4);
        expect_bits("cont_p3", 32'b11, 2);
        chk("cont_p3_bit2", 4'b0110);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_out", 4'b0000);
        tick();
        chk("abort_no_done", 4'b0000);

        // Oversize length clamps to full width, multi-pass count
        pattern = 9'b100000001; pat_len = 4'd15; reps = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        expect_bits("clamp_p0", 32'b100000001, 9);
        expect_bits("clamp_p1", 32'b100000001, 9);
        chk("clamp_done", 4'b0011);
        tick();
        chk("clamp_idle", 4'b0000);

        // Asynchronous reset mid-pass, between edges
        pattern = 9'b111111111; pat_len = 4'd0; reps = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("pre_reset_bit0", 4'b1110);
        tick();
        #2;
        state_reset = 1'b0;
        #1;
        chk("async_reset", 4'b0000);
        tick();
        chk("held_reset", 4'b0000);
        @(negedge clk);
        state_reset = 1'b1;
        pattern = 9'b001011110; pat_len = 4'd0; reps = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        expect_bits("post_reset", 32'b001011110, 9);
        chk("post_reset_done", 4'b0011);
        tick();
        chk("post_reset_idle", 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
